// File: rtl/vga_pixel_out.sv
`default_nettype none
// ============================================================================
// Module  : vga_pixel_out
// Brief   : VGA timing generator that streams pixels from a show-ahead FIFO,
//           with frame-aligned start and a sticky underrun flag.
// Revision: 1.0 - initial release
// ============================================================================
module vga_pixel_out #(
    parameter int HDISP  = 800,
    parameter int VDISP  = 480,
    parameter int HFP    = 40,
    parameter int HPULSE = 48,
    parameter int HBP    = 40,
    parameter int VFP    = 13,
    parameter int VPULSE = 3,
    parameter int VBP    = 29
) (
    input  logic        pixel_clk,
    input  logic        pixel_rst,
    input  logic [23:0] fifo_rdata,
    input  logic        fifo_empty,
    output logic        fifo_rinc,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK,
    output logic        VGA_SYNC,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        underrun
);

    localparam int c_HTOTAL = HFP + HPULSE + HBP + HDISP;
    localparam int c_VTOTAL = VFP + VPULSE + VBP + VDISP;
    localparam int HW       = $clog2(c_HTOTAL);
    localparam int VW       = $clog2(c_VTOTAL);

    localparam logic [HW-1:0] c_HLAST  = HW'(c_HTOTAL - 1);
    localparam logic [VW-1:0] c_VLAST  = VW'(c_VTOTAL - 1);
    localparam logic [HW-1:0] c_HSTART = HW'(c_HTOTAL - HDISP);
    localparam logic [VW-1:0] c_VSTART = VW'(c_VTOTAL - VDISP);
    localparam logic [HW-1:0] c_HPBEG  = HW'(HFP);
    localparam logic [HW-1:0] c_HPEND  = HW'(HFP + HPULSE);
    localparam logic [VW-1:0] c_VPBEG  = VW'(VFP);
    localparam logic [VW-1:0] c_VPEND  = VW'(VFP + VPULSE);

    typedef enum logic [0:0] {
        WAIT_FRAME = 1'b0,
        STREAM     = 1'b1
    } state_t;

    state_t          r_state;
    logic            r_drop;
    logic [HW-1:0]   r_hcnt;
    logic [VW-1:0]   r_vcnt;
    logic            r_hs;
    logic            r_vs;
    logic            r_blank;
    logic [23:0]     r_rgb;
    logic            r_underrun;

    logic            w_hlast;
    logic            w_frame_end;
    logic            w_active;
    logic            w_hpulse;
    logic            w_vpulse;
    logic            w_starved;
    logic            w_pop;

    assign w_hlast     = (r_hcnt == c_HLAST);
    assign w_frame_end = w_hlast && (r_vcnt == c_VLAST);
    assign w_active    = (r_hcnt >= c_HSTART) && (r_vcnt >= c_VSTART);
    assign w_hpulse    = (r_hcnt >= c_HPBEG) && (r_hcnt < c_HPEND);
    assign w_vpulse    = (r_vcnt >= c_VPBEG) && (r_vcnt < c_VPEND);
    assign w_starved   = (r_state == STREAM) && w_active && fifo_empty;
    // After an underrun the rest of the frame is abandoned (r_drop) so the
    // FIFO contents stay aligned to the start of the next streamed frame.
    assign w_pop       = (r_state == STREAM) && !r_drop && w_active && !fifo_empty;

    assign fifo_rinc = w_pop;
    assign VGA_HS    = r_hs;
    assign VGA_VS    = r_vs;
    assign VGA_BLANK = r_blank;
    assign VGA_SYNC  = 1'b0;
    assign VGA_R     = r_rgb[23:16];
    assign VGA_G     = r_rgb[15:8];
    assign VGA_B     = r_rgb[7:0];
    assign underrun  = r_underrun;

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (w_hlast) begin
            r_hcnt <= '0;
            r_vcnt <= (r_vcnt == c_VLAST) ? '0 : r_vcnt + 1'b1;
        end else begin
            r_hcnt <= r_hcnt + 1'b1;
        end
    end

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            r_state    <= WAIT_FRAME;
            r_drop     <= 1'b0;
            r_hs       <= 1'b1;
            r_vs       <= 1'b1;
            r_blank    <= 1'b0;
            r_rgb      <= 24'h0;
            r_underrun <= 1'b0;
        end else begin
            r_hs    <= !w_hpulse;
            r_vs    <= !w_vpulse;
            r_blank <= w_active;
            r_rgb   <= w_pop ? fifo_rdata : 24'h0;
            if (w_starved) begin
                r_underrun <= 1'b1;
            end
            case (r_state)
                WAIT_FRAME: begin
                    r_drop <= 1'b0;
                    if (w_frame_end && !fifo_empty) begin
                        r_state <= STREAM;
                    end
                end
                STREAM: begin
                    if (w_frame_end) begin
                        r_drop <= 1'b0;
                        if (r_drop || w_starved) begin
                            r_state <= WAIT_FRAME;
                        end
                    end else if (w_starved) begin
                        r_drop <= 1'b1;
                    end
                end
                default: begin
                    r_state <= WAIT_FRAME;
                    r_drop  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_out.sv
`default_nettype none
// ============================================================================
// Module  : tb_vga_pixel_out
// Brief   : Self-checking bench: default-timing instance with empty FIFO and a
//           reduced-timing instance checked against a frame-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_vga_pixel_out;

    localparam int SHD = 8;
    localparam int SVD = 4;
    localparam int SP  = 2;
    localparam int HT  = SHD + 3 * SP;   // 14
    localparam int VT  = SVD + 3 * SP;   // 10
    localparam int HST = HT - SHD;
    localparam int VST = VT - SVD;
    localparam int FR  = HT * VT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       d_rst;
    logic       d_rinc, d_hs, d_vs, d_blank, d_sync, d_under;
    logic [7:0] d_r, d_g, d_b;

    logic        s_rst;
    logic [23:0] s_rdata;
    logic        s_empty;
    logic        s_rinc, s_hs, s_vs, s_blank, s_sync, s_under;
    logic [7:0]  s_r, s_g, s_b;

    vga_pixel_out u_def (
        .pixel_clk (clk),
        .pixel_rst (d_rst),
        .fifo_rdata(24'hA5A5A5),
        .fifo_empty(1'b1),
        .fifo_rinc (d_rinc),
        .VGA_HS    (d_hs),
        .VGA_VS    (d_vs),
        .VGA_BLANK (d_blank),
        .VGA_SYNC  (d_sync),
        .VGA_R     (d_r),
        .VGA_G     (d_g),
        .VGA_B     (d_b),
        .underrun  (d_under)
    );

    vga_pixel_out #(
        .HDISP(SHD), .VDISP(SVD),
        .HFP(SP), .HPULSE(SP), .HBP(SP),
        .VFP(SP), .VPULSE(SP), .VBP(SP)
    ) u_small (
        .pixel_clk (clk),
        .pixel_rst (s_rst),
        .fifo_rdata(s_rdata),
        .fifo_empty(s_empty),
        .fifo_rinc (s_rinc),
        .VGA_HS    (s_hs),
        .VGA_VS    (s_vs),
        .VGA_BLANK (s_blank),
        .VGA_SYNC  (s_sync),
        .VGA_R     (s_r),
        .VGA_G     (s_g),
        .VGA_B     (s_b),
        .underrun  (s_under)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a frame is "live" once the FIFO was non-empty at the
    // preceding frame boundary; a starved pixel kills the rest of that frame
    // and the next boundary cannot restart streaming.
    int          m_t;
    bit          m_live, m_dead, m_under;
    logic        e_hs, e_vs, e_blank;
    logic [23:0] e_rgb;
    logic [23:0] data_ctr;
    int          dut_pops, last_pops, first_pop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, m_t);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_live = 0; m_dead = 0; m_under = 0;
        e_hs = 1; e_vs = 1; e_blank = 0; e_rgb = 0;
        dut_pops = 0; last_pops = -1; first_pop = -1;
    endtask

    task automatic chk_small_reset(input string tag);
        chk({tag, "_hs"},    s_hs, 1);
        chk({tag, "_vs"},    s_vs, 1);
        chk({tag, "_blank"}, s_blank, 0);
        chk({tag, "_rgb"},   {s_r, s_g, s_b}, 0);
        chk({tag, "_under"}, s_under, 0);
        chk({tag, "_rinc"},  s_rinc, 0);
    endtask

    // Entered at posedge+1; leaves the DUT released so the next posedge counts t=0.
    task automatic s_restart();
        s_rst = 1'b1;
        @(posedge clk); #1;
        chk_small_reset("rst");
        s_rst = 1'b0;
        model_reset();
    endtask

    task automatic s_step(input bit empty, input logic [23:0] word);
        int  h, v;
        bit  act, pop, fe;
        @(negedge clk);
        s_empty = empty;
        s_rdata = word;
        h   = m_t % HT;
        v   = (m_t / HT) % VT;
        act = (h >= HST) && (v >= VST);
        fe  = (h == HT - 1) && (v == VT - 1);
        pop = m_live && !m_dead && act && !empty;
        #1 chk("rinc", s_rinc, pop);
        if (s_rinc === 1'b1) begin
            dut_pops++;
            if (first_pop < 0) first_pop = m_t;
        end
        e_hs    = !(h >= SP && h < 2 * SP);
        e_vs    = !(v >= SP && v < 2 * SP);
        e_blank = act;
        e_rgb   = pop ? word : 24'h0;
        if (m_live && act && empty) m_under = 1;
        if (fe) begin
            m_live    = m_live ? !(m_dead || (act && empty)) : !empty;
            m_dead    = 0;
            last_pops = dut_pops;
            dut_pops  = 0;
        end else if (m_live && act && empty) begin
            m_dead = 1;
        end
        m_t++;
        @(posedge clk); #1;
        chk("hs",    s_hs, e_hs);
        chk("vs",    s_vs, e_vs);
        chk("blank", s_blank, e_blank);
        chk("rgb",   {s_r, s_g, s_b}, e_rgb);
        chk("under", s_under, m_under);
        chk("sync",  s_sync, 0);
    endtask

    // Non-empty step whose word tracks what an in-order FIFO would present.
    task automatic s_full();
        logic [23:0] w;
        w = data_ctr;
        s_step(1'b0, w);
        if (e_rgb === w && w != 24'h0) data_ctr = data_ctr + 24'd1;
    endtask

    task automatic frames_full(input int n);
        for (int i = 0; i < n * FR; i++) begin
            data_ctr = data_ctr + ((m_live && !m_dead) ? 24'd0 : 24'd0);
            s_full();
        end
    endtask

    initial begin
        d_rst = 1'b1; s_rst = 1'b1; s_empty = 1'b1; s_rdata = 24'h0;
        data_ctr = 24'h000001;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("def_rst_hs", d_hs, 1);
        chk("def_rst_vs", d_vs, 1);
        chk("def_rst_blank", d_blank, 0);
        chk("def_rst_under", d_under, 0);
        chk_small_reset("hold");

        // Default timing, FIFO always empty: 16 full lines.
        d_rst = 1'b0;
        for (int k = 1; k <= 16 * 928; k++) begin
            int t;
            @(posedge clk); #1;
            t = k - 1;
            chk("def_hs",   d_hs, !((t % 928) >= 40 && (t % 928) < 88));
            chk("def_vs",   d_vs, !((t / 928) >= 13 && (t / 928) < 16));
            chk("def_rinc", d_rinc, 0);
            chk("def_rgb",  {d_r, d_g, d_b}, 0);
        end

        // Empty for a frame and a half, then data appears mid-frame in WAIT_FRAME.
        s_restart();
        for (int i = 0; i < FR + FR / 2; i++) s_step(1'b1, 24'h0);
        frames_full(1);
        chk("late_data_pops", last_pops, 0);
        frames_full(2);
        chk("late_stream_pops", last_pops, 32);

        // FIFO always full from reset release: first pop in the second frame.
        s_restart();
        frames_full(4);
        chk("first_pop_t", first_pop, FR + VST * HT + HST);
        chk("full_frame_pops", last_pops, 32);

        // Single starved pixel at (HST+2, VST+1) of a streamed frame.
        for (int i = 0; i < FR; i++) begin
            if ((m_t % HT) == HST + 2 && ((m_t / HT) % VT) == VST + 1) s_step(1'b1, 24'h0);
            else s_full();
        end
        chk("underrun_frame_pops", last_pops, SHD + 2);
        chk("underrun_set", s_under, 1);
        frames_full(1);
        chk("after_underrun_pops", last_pops, 0);
        frames_full(1);
        chk("resume_pops", last_pops, 32);
        chk("underrun_sticky", s_under, 1);

        // Randomised FIFO availability and data.
        for (int i = 0; i < 8 * FR; i++) begin
            s_step(($urandom_range(0, 29) == 0), 24'($urandom));
        end

        // Asynchronous reset pulse in the middle of an active streamed line.
        s_restart();
        while (m_t != FR + (VST + 1) * HT + HST + 3) s_full();
        chk("pre_rst_blank", s_blank, 1);
        #2 s_rst = 1'b1;
        #1 chk_small_reset("async");
        #60 chk_small_reset("async_hold");
        #67 s_rst = 1'b0;
        model_reset();
        frames_full(1);
        chk("post_rst_pops", last_pops, 0);
        frames_full(1);
        chk("post_rst_stream_pops", last_pops, 32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
